// File: rtl/mem_stage.sv
// Memory/writeback stage: turns execute results into a single registered register-file write,
// drives data-RAM port B for loads/stores and holds the upstream pipeline while a load is in flight.
module mem_stage #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned DISCARD_REG  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            ex_op,
  input  logic [REG_AW-1:0]     ex_dest,
  input  logic [DATA_WIDTH-1:0] ex_value,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic                  ex_wr_en,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_enable,
  output logic [REG_AW-1:0]     wb_dest,
  output logic [DATA_WIDTH-1:0] wb_value
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_LD_WAIT = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SET  = 4'd1;
  localparam logic [3:0] OP_SHFT = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;

  localparam logic [REG_AW-1:0] DISCARD = REG_AW'(DISCARD_REG);
  localparam logic [1:0]        LAT     = 2'(LOAD_LATENCY);

  logic [0:0]            state_q,     state_d;
  logic [1:0]            cnt_q,       cnt_d;
  logic [REG_AW-1:0]     ld_dest_q,   ld_dest_d;
  logic [DATA_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_wren_q,  mem_wren_d;
  logic                  wb_enable_q, wb_enable_d;
  logic [REG_AW-1:0]     wb_dest_q,   wb_dest_d;
  logic [DATA_WIDTH-1:0] wb_value_q,  wb_value_d;

  // Next-state: accept a new op in IDLE, or count down an outstanding load and write it back.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_dest_d   = ld_dest_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    wb_enable_d = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_value_d  = wb_value_q;
    case (state_q)
      ST_IDLE: begin
        case (ex_op)
          OP_ADD, OP_SET, OP_SHFT, OP_CALL: begin
            if (ex_wr_en && (ex_dest != DISCARD)) begin
              wb_enable_d = 1'b1;
              wb_dest_d   = ex_dest;
              wb_value_d  = ex_value;
            end else begin
              wb_enable_d = 1'b0;
            end
          end
          OP_ST: begin
            mem_wren_d  = 1'b1;
            mem_addr_d  = ex_value;
            mem_wdata_d = ex_store_data;
          end
          OP_LD: begin
            ld_dest_d  = ex_dest;
            mem_addr_d = ex_value;
            cnt_d      = LAT;
            state_d    = ST_LD_WAIT;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_LD_WAIT: begin
        // The load still completes for the discard register; only the strobe is suppressed.
        if (cnt_q == 2'd0) begin
          state_d = ST_IDLE;
          if (ld_dest_q != DISCARD) begin
            wb_enable_d = 1'b1;
            wb_dest_d   = ld_dest_q;
            wb_value_d  = mem_rdata;
          end else begin
            wb_enable_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      ld_dest_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      wb_enable_q <= 1'b0;
      wb_dest_q   <= '0;
      wb_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_dest_q   <= ld_dest_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      wb_enable_q <= wb_enable_d;
      wb_dest_q   <= wb_dest_d;
      wb_value_q  <= wb_value_d;
    end
  end

  assign stall     = (state_q == ST_LD_WAIT);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign wb_enable = wb_enable_q;
  assign wb_dest   = wb_dest_q;
  assign wb_value  = wb_value_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (load latency 1 and 3), each with a small RAM model,
// checked every cycle against a transaction-level reference model.
module tb_mem_stage;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]    ex_op     [2];
  logic [AW-1:0] ex_dest   [2];
  logic [DW-1:0] ex_value  [2];
  logic [DW-1:0] ex_sdata  [2];
  logic          ex_wr_en  [2];
  logic          stall     [2];
  logic [DW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic          mem_wren  [2];
  logic [DW-1:0] mem_rdata [2];
  logic          wb_en     [2];
  logic [AW-1:0] wb_dest   [2];
  logic [DW-1:0] wb_value  [2];

  mem_stage #(.DATA_WIDTH(16), .REG_AW(3), .LOAD_LATENCY(1), .DISCARD_REG(7)) u_l1 (
    .clk(clk), .reset(reset), .ex_op(ex_op[0]), .ex_dest(ex_dest[0]), .ex_value(ex_value[0]),
    .ex_store_data(ex_sdata[0]), .ex_wr_en(ex_wr_en[0]), .stall(stall[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wren(mem_wren[0]),
    .mem_rdata(mem_rdata[0]), .wb_enable(wb_en[0]), .wb_dest(wb_dest[0]), .wb_value(wb_value[0]));

  mem_stage #(.DATA_WIDTH(16), .REG_AW(3), .LOAD_LATENCY(3), .DISCARD_REG(7)) u_l3 (
    .clk(clk), .reset(reset), .ex_op(ex_op[1]), .ex_dest(ex_dest[1]), .ex_value(ex_value[1]),
    .ex_store_data(ex_sdata[1]), .ex_wr_en(ex_wr_en[1]), .stall(stall[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wren(mem_wren[1]),
    .mem_rdata(mem_rdata[1]), .wb_enable(wb_en[1]), .wb_dest(wb_dest[1]), .wb_value(wb_value[1]));

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a * 40503) ^ 16'h5A5A;
  endfunction

  // RAM models: 256 words indexed by the low address byte, read latency 1 (pipe[0]) or 3 (pipe[2])
  logic [DW-1:0] ram  [2][256];
  logic [DW-1:0] pipe [2][3];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < 256; i++) ram[k][i] <= init_word(i);
      end else if (mem_wren[k]) begin
        ram[k][mem_addr[k][7:0]] <= mem_wdata[k];
      end
      pipe[k][0] <= ram[k][mem_addr[k][7:0]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // Reference model state: memory image, one outstanding load, expected outputs
  int            lat [2] = '{1, 3};
  logic [DW-1:0] mram [2][256];
  bit            pend_v [2];
  int            pend_left [2];
  logic [AW-1:0] pend_dest [2];
  logic [DW-1:0] pend_addr [2];
  bit            e_wb_en [2];
  logic [AW-1:0] e_wb_dest [2];
  logic [DW-1:0] e_wb_val [2];
  bit            e_wren [2];
  logic [DW-1:0] e_addr [2];
  logic [DW-1:0] e_wdata [2];
  bit            e_rst [2];
  bit            acc_r [2];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s[L%0d] observed=%0h expected=%0h t=%0t", tag, lat[k], obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int k, input bit rst, output bit acc);
    acc = 1'b0;
    e_wb_en[k] = 1'b0;
    e_wren[k]  = 1'b0;
    e_rst[k]   = rst;
    if (rst) begin
      pend_v[k] = 1'b0;
      e_addr[k] = '0; e_wdata[k] = '0; e_wb_dest[k] = '0; e_wb_val[k] = '0;
      for (int i = 0; i < 256; i++) mram[k][i] = init_word(i);
    end else if (pend_v[k]) begin
      pend_left[k]--;
      if (pend_left[k] == 0) begin
        pend_v[k] = 1'b0;
        if (pend_dest[k] != 3'd7) begin
          e_wb_en[k]   = 1'b1;
          e_wb_dest[k] = pend_dest[k];
          e_wb_val[k]  = mram[k][pend_addr[k][7:0]];
        end
      end
    end else begin
      acc = 1'b1;
      case (ex_op[k])
        4'd0, 4'd1, 4'd3, 4'd4: begin
          if (ex_wr_en[k] && ex_dest[k] != 3'd7) begin
            e_wb_en[k]   = 1'b1;
            e_wb_dest[k] = ex_dest[k];
            e_wb_val[k]  = ex_value[k];
          end
        end
        4'd7: begin
          e_wren[k]  = 1'b1;
          e_addr[k]  = ex_value[k];
          e_wdata[k] = ex_sdata[k];
          mram[k][ex_value[k][7:0]] = ex_sdata[k];
        end
        4'd6: begin
          pend_v[k]    = 1'b1;
          pend_left[k] = lat[k] + 1;
          pend_dest[k] = ex_dest[k];
          pend_addr[k] = ex_value[k];
          e_addr[k]    = ex_value[k];
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input int k);
    chk(k, "stall", 32'(stall[k]), 32'(pend_v[k]));
    chk(k, "wb_enable", 32'(wb_en[k]), 32'(e_wb_en[k]));
    chk(k, "mem_wren", 32'(mem_wren[k]), 32'(e_wren[k]));
    chk(k, "mem_addr", 32'(mem_addr[k]), 32'(e_addr[k]));
    chk(k, "mem_wdata", 32'(mem_wdata[k]), 32'(e_wdata[k]));
    if (e_wb_en[k] || e_rst[k]) begin
      chk(k, "wb_dest", 32'(wb_dest[k]), 32'(e_wb_dest[k]));
      chk(k, "wb_value", 32'(wb_value[k]), 32'(e_wb_val[k]));
    end
  endtask

  task automatic tick(input bit rst);
    bit a;
    reset = rst;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      model_edge(k, rst, a);
      acc_r[k] = a;
    end
    #1;
    for (int k = 0; k < 2; k++) check(k);
    reset = 1'b0;
  endtask

  task automatic set_nop(input int k);
    ex_op[k] = 4'd2; ex_dest[k] = '0; ex_value[k] = '0; ex_sdata[k] = '0; ex_wr_en[k] = 1'b0;
  endtask

  // Present one op to instance k, holding it while stalled until it is accepted
  task automatic issue(input int k, input logic [3:0] op, input logic [AW-1:0] dest,
                       input logic [DW-1:0] val, input logic [DW-1:0] sd, input logic we);
    int n;
    set_nop(1 - k);
    ex_op[k] = op; ex_dest[k] = dest; ex_value[k] = val; ex_sdata[k] = sd; ex_wr_en[k] = we;
    n = 0;
    do begin
      tick(1'b0);
      n++;
    end while (!acc_r[k] && n < 12);
    chk(k, "accept_bound", 32'(acc_r[k]), 32'd1);
    set_nop(k);
  endtask

  initial begin
    set_nop(0);
    set_nop(1);
    reset = 1'b1;
    tick(1'b1);
    tick(1'b1);
    // ALU writeback, then low the cycle after
    issue(0, 4'd0, 3'd3, 16'h1234, 16'h0000, 1'b1);
    tick(1'b0);
    // store 0xBEEF at 0x40 on both instances
    issue(0, 4'd7, 3'd5, 16'h0040, 16'hBEEF, 1'b1);
    issue(1, 4'd7, 3'd5, 16'h0040, 16'hBEEF, 1'b0);
    tick(1'b0);
    // load back: latency 1 then latency 3
    issue(0, 4'd6, 3'd2, 16'h0040, 16'h0000, 1'b0);
    repeat (3) tick(1'b0);
    issue(1, 4'd6, 3'd2, 16'h0040, 16'h0000, 1'b0);
    repeat (5) tick(1'b0);
    // discard register never written back
    issue(0, 4'd0, 3'd7, 16'h00FF, 16'h0000, 1'b1);
    issue(0, 4'd6, 3'd7, 16'h0040, 16'h0000, 1'b0);
    issue(1, 4'd6, 3'd7, 16'h0040, 16'h0000, 1'b0);
    repeat (5) tick(1'b0);
    // reset while loads are outstanding
    issue(0, 4'd6, 3'd4, 16'h0040, 16'h0000, 1'b0);
    issue(1, 4'd6, 3'd4, 16'h0040, 16'h0000, 1'b0);
    tick(1'b1);
    repeat (5) tick(1'b0);
    // stream ADD / LD / ADD with the second ADD held during the stall
    issue(0, 4'd7, 3'd0, 16'h0010, 16'h5555, 1'b0);
    issue(0, 4'd0, 3'd1, 16'h0001, 16'h0000, 1'b1);
    issue(0, 4'd6, 3'd2, 16'h0010, 16'h0000, 1'b0);
    issue(0, 4'd0, 3'd3, 16'h0003, 16'h0000, 1'b1);
    repeat (3) tick(1'b0);
    // randomized traffic on both instances, narrow address range to make loads hit stores
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        tick(1'b1);
      end else begin
        issue(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              {8'($urandom_range(0, 255)), 4'h0, 4'($urandom_range(0, 15))},
              16'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    repeat (6) tick(1'b0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
